// File: rtl/cr_tlv_gen_pkg.sv
// cr_tlv_gen_pkg
// Shared types and constants for the TLV generator:
//   axi4s_dp_bus_t  - datapath AXI4-stream beat (tvalid, tlast, tid, tstrb, tuser, tdata)
//   axi4s_dp_rdy_t  - datapath AXI4-stream ready (tready)
//   TLV_SOT_BIT / TLV_EOT_BIT - tuser framing bit positions
//   TLV header field positions, generator FSM state enum, header/tuser helpers
package cr_tlv_gen_pkg;

  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic        tid;
    logic [7:0]  tstrb;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

  localparam int unsigned TLV_SOT_BIT = 0;
  localparam int unsigned TLV_EOT_BIT = 1;

  localparam int unsigned TLV_HDR_TYPE_LSB = 0;
  localparam int unsigned TLV_HDR_TYPE_MSB = 7;
  localparam int unsigned TLV_HDR_LEN_LSB  = 8;
  localparam int unsigned TLV_HDR_LEN_MSB  = 15;
  localparam int unsigned TLV_HDR_EXT_LSB  = 16;
  localparam int unsigned TLV_HDR_EXT_MSB  = 63;

  typedef enum logic [1:0] {
    TLV_GEN_IDLE = 2'd0,
    TLV_GEN_HDR  = 2'd1,
    TLV_GEN_PLD  = 2'd2
  } tlv_gen_state_e;

  function automatic logic [63:0] tlv_hdr_word(input logic [7:0]  typ,
                                               input logic [7:0]  len,
                                               input logic [47:0] ext);
    logic [63:0] w;
    w = '0;
    w[TLV_HDR_TYPE_MSB:TLV_HDR_TYPE_LSB] = typ;
    w[TLV_HDR_LEN_MSB:TLV_HDR_LEN_LSB]   = len;
    w[TLV_HDR_EXT_MSB:TLV_HDR_EXT_LSB]   = ext;
    return w;
  endfunction

  function automatic logic [7:0] tlv_tuser(input logic sot, input logic eot);
    logic [7:0] u;
    u = '0;
    u[TLV_SOT_BIT] = sot;
    u[TLV_EOT_BIT] = eot;
    return u;
  endfunction

endpackage

// File: rtl/cr_tlv_gen_if.sv
// cr_tlv_gen_if
// Command and payload handshakes between a user module and cr_tlv_gen.
//   master: user side (drives cmd_* / pld_valid / pld_data)
//   slave : generator side (drives cmd_ready / pld_ready)
interface cr_tlv_gen_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_type;
  logic [7:0]  cmd_len;
  logic [47:0] cmd_hdr_ext;
  logic        cmd_eof;
  logic [7:0]  cmd_last_strb;
  logic        cmd_tid;
  logic        pld_valid;
  logic        pld_ready;
  logic [63:0] pld_data;

  modport master (
    output cmd_valid, cmd_type, cmd_len, cmd_hdr_ext, cmd_eof, cmd_last_strb, cmd_tid,
    output pld_valid, pld_data,
    input  cmd_ready, pld_ready
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_len, cmd_hdr_ext, cmd_eof, cmd_last_strb, cmd_tid,
    input  pld_valid, pld_data,
    output cmd_ready, pld_ready
  );
endinterface

// File: rtl/cr_tlv_gen_obuf.sv
// cr_tlv_gen_obuf
// Two-entry skid buffer in front of the AXI4-stream master port.
//   clk, rst_n   - clock, async active-low reset
//   i_push       - write a beat (ignored when full unless the head pops)
//   i_data       - beat to write (tvalid field is ignored)
//   o_full       - both entries occupied
//   o_out        - registered head beat; tvalid = buffer non-empty
//   i_rdy        - downstream tready
module cr_tlv_gen_obuf
  import cr_tlv_gen_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  axi4s_dp_bus_t i_data,
  output logic          o_full,
  output axi4s_dp_bus_t o_out,
  input  axi4s_dp_rdy_t i_rdy
);

  axi4s_dp_bus_t r_out;
  axi4s_dp_bus_t r_skid;
  axi4s_dp_bus_t w_in;
  logic          w_pop;
  logic          w_out_free;

  always_comb begin
    w_in        = i_data;
    w_in.tvalid = 1'b1;
  end

  assign w_pop      = r_out.tvalid & i_rdy.tready;
  assign w_out_free = ~r_out.tvalid | w_pop;
  assign o_full     = r_out.tvalid & r_skid.tvalid;
  assign o_out      = r_out;

  // The skid entry is always older than a new push, so it moves to the head
  // first; the head register itself is the only thing the port ever sees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_skid <= '0;
    end else if (w_out_free) begin
      if (r_skid.tvalid) begin
        r_out  <= r_skid;
        r_skid <= i_push ? w_in : '0;
      end else begin
        r_out  <= i_push ? w_in : '0;
      end
    end else if (i_push && !r_skid.tvalid) begin
      r_skid <= w_in;
    end
  end

endmodule

// File: rtl/cr_tlv_gen.sv
// cr_tlv_gen
// Serializes TLVs (one header beat + payload beats) onto the 64-bit
// AXI4-stream datapath bus with SOT/EOT/tlast/tstrb framing.
//   clk, rst_n     - clock, async active-low reset
//   tlv_if         - command + payload handshakes (slave side)
//   axi4s_ob_out   - AXI4-stream master beat
//   axi4s_ob_in    - AXI4-stream tready
//   tlv_gen_error  - sticky, set by a zero-length command
//   tlv_cnt        - count of TLVs whose EOT beat has been pushed (wraps)
module cr_tlv_gen
  import cr_tlv_gen_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cr_tlv_gen_if.slave          tlv_if,
  output axi4s_dp_bus_t        axi4s_ob_out,
  input  axi4s_dp_rdy_t        axi4s_ob_in,
  output logic                 tlv_gen_error,
  output logic [CNT_WIDTH-1:0] tlv_cnt
);

  tlv_gen_state_e r_state;
  tlv_gen_state_e w_state_nxt;

  logic [7:0]           r_type;
  logic [7:0]           r_len;
  logic [47:0]          r_ext;
  logic                 r_eof;
  logic [7:0]           r_strb;
  logic                 r_tid;
  logic [7:0]           r_remaining;
  logic                 r_err;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic          w_cmd_xfer;
  logic          w_pld_xfer;
  logic          w_push;
  logic          w_eot_push;
  logic          w_full;
  axi4s_dp_bus_t w_beat;

  // Gated by rst_n so the command port is not ready while held in reset.
  assign tlv_if.cmd_ready = rst_n & (r_state == TLV_GEN_IDLE);
  assign tlv_if.pld_ready = (r_state == TLV_GEN_PLD) & ~w_full;

  assign w_cmd_xfer = tlv_if.cmd_valid & tlv_if.cmd_ready;
  assign w_pld_xfer = tlv_if.pld_valid & tlv_if.pld_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_eot_push  = 1'b0;
    w_beat      = '0;
    w_beat.tid  = r_tid;
    case (r_state)
      TLV_GEN_IDLE: begin
        if (w_cmd_xfer && (tlv_if.cmd_len != 8'd0)) w_state_nxt = TLV_GEN_HDR;
      end
      TLV_GEN_HDR: begin
        if (!w_full) begin
          w_push       = 1'b1;
          w_beat.tdata = tlv_hdr_word(r_type, r_len, r_ext);
          if (r_len == 8'd1) begin
            w_eot_push   = 1'b1;
            w_beat.tuser = tlv_tuser(1'b1, 1'b1);
            w_beat.tlast = r_eof;
            w_beat.tstrb = r_strb;
            w_state_nxt  = TLV_GEN_IDLE;
          end else begin
            w_beat.tuser = tlv_tuser(1'b1, 1'b0);
            w_beat.tstrb = 8'hFF;
            w_state_nxt  = TLV_GEN_PLD;
          end
        end
      end
      TLV_GEN_PLD: begin
        if (w_pld_xfer) begin
          w_push       = 1'b1;
          w_beat.tdata = tlv_if.pld_data;
          if (r_remaining == 8'd1) begin
            w_eot_push   = 1'b1;
            w_beat.tuser = tlv_tuser(1'b0, 1'b1);
            w_beat.tlast = r_eof;
            w_beat.tstrb = r_strb;
            w_state_nxt  = TLV_GEN_IDLE;
          end else begin
            w_beat.tuser = tlv_tuser(1'b0, 1'b0);
            w_beat.tstrb = 8'hFF;
          end
        end
      end
      default: w_state_nxt = TLV_GEN_IDLE;
    endcase
    w_beat.tvalid = w_push;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= TLV_GEN_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type      <= '0;
      r_len       <= '0;
      r_ext       <= '0;
      r_eof       <= 1'b0;
      r_strb      <= '0;
      r_tid       <= 1'b0;
      r_remaining <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_cmd_xfer) begin
        r_type <= tlv_if.cmd_type;
        r_len  <= tlv_if.cmd_len;
        r_ext  <= tlv_if.cmd_hdr_ext;
        r_eof  <= tlv_if.cmd_eof;
        r_strb <= tlv_if.cmd_last_strb;
        r_tid  <= tlv_if.cmd_tid;
        if (tlv_if.cmd_len == 8'd0) r_err <= 1'b1;
      end
      if ((r_state == TLV_GEN_HDR) && w_push) r_remaining <= r_len - 8'd1;
      else if (w_pld_xfer)                    r_remaining <= r_remaining - 8'd1;
      if (w_eot_push) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tlv_gen_error = r_err;
  assign tlv_cnt       = r_cnt;

  cr_tlv_gen_obuf u_obuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_data (w_beat),
    .o_full (w_full),
    .o_out  (axi4s_ob_out),
    .i_rdy  (axi4s_ob_in)
  );

endmodule

// File: doc/cr_tlv_gen.md
# cr_tlv_gen

Serializes TLVs into the 64-bit AXI4-stream datapath bus. A user module supplies a per-TLV command (type, length, header extension, end-of-frame marking) plus a payload word stream. The block emits one header beat followed by the payload beats, with SOT/EOT/tlast/tstrb framing that `cr_tlvp` parses on the receiving side. It sits at the ingress of a TLV chain (CCEIP source / test generator) and drives an `axi4s_dp_bus_t` master port directly.

## Interface

Parameters:
- `CNT_WIDTH`, 32, width of the emitted-TLV statistics counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake; transfer when both are high.
- `cmd_type`  in  8  TLV type.
- `cmd_len`  in  8  total TLV words including header; 0 is illegal.
- `cmd_hdr_ext`  in  48  header bits [63:16].
- `cmd_eof`  in  1  assert tlast on the final word of this TLV.
- `cmd_last_strb`  in  8  tstrb for the final word; must be nonzero.
- `cmd_tid`  in  1  tid for all beats of this TLV.
- `pld_valid` in 1, `pld_ready` out 1, `pld_data` in 64: payload word handshake.
- `axi4s_ob_out`  out  axi4s_dp_bus_t  tvalid, tlast, tid, tstrb[7:0], tuser[7:0], tdata[63:0].
- `axi4s_ob_in`  in  axi4s_dp_rdy_t  tready.
- `tlv_gen_error`  out  1  sticky; set on an illegal command.
- `tlv_cnt`  out  CNT_WIDTH  TLVs fully pushed to the output buffer; wraps.

## Operation

FSM states: IDLE, HDR, PLD.

- **IDLE**
  - `cmd_ready`=1.
  - On a command transfer, latch all cmd fields.
  - `cmd_len`==0: set `tlv_gen_error`, drop the command, stay in IDLE.
  - Otherwise go to HDR.
- **HDR**
  - `cmd_ready`=0.
  - When the output buffer is not full, push the header beat: tdata[7:0]=type, [15:8]=len, [63:16]=hdr_ext; tuser[0]=SOT=1.
  - If len==1: the header also carries tuser[1]=EOT=1, tlast=eof, tstrb=last_strb; go to IDLE.
  - Otherwise header tstrb=8'hFF, tlast=0; set `remaining`=len-1; go to PLD.
- **PLD**
  - `pld_ready` = ~obuf_full.
  - Each payload transfer pushes one beat with tdata=`pld_data` and `remaining` decrements.
  - Beat with `remaining`==1: EOT=1, tlast=eof, tstrb=last_strb; go to IDLE.
  - All other payload beats: tstrb=8'hFF, SOT=EOT=tlast=0.
- `pld_ready`=0 outside PLD. Payload presented early waits; it is never consumed in IDLE or HDR.
- tuser[7:2]=0 always. tid=latched `cmd_tid` on every beat.
- `tlv_cnt` increments in the cycle the EOT beat is pushed.
- The error is sticky until reset; an error never blocks further commands.

## Timing

- Reset values:
  - `axi4s_ob_out` all fields 0.
  - `cmd_ready`=0 while `rst_n` is low; 1 in the first cycle after deassertion.
  - `pld_ready`=0, `tlv_gen_error`=0, `tlv_cnt`=0, FSM=IDLE, output buffer empty.
- Output is fully registered through a 2-entry skid buffer.
  - tvalid is high whenever the buffer is non-empty.
  - A beat pops on tvalid&tready.
  - Beats and fields are held stable while tready=0.
- Latency and throughput:
  - Command accepted in cycle N → header on `axi4s_ob_out` in cycle N+2 (HDR push at N+1, registered).
  - The first payload word accepted in cycle M appears at M+1 when the buffer is empty.
  - Steady-state rate: len beats per len+1 cycles (one IDLE bubble per TLV).
- Buffer full: no push, FSM holds state, `pld_ready`=0.
- Push and pop in the same cycle with the buffer full is allowed (occupancy unchanged).
- The buffer never drops or duplicates a beat.
- Reset mid-TLV:
  - All state clears immediately (async).
  - Partial TLV beats in the buffer are discarded.
  - No recovery framing is emitted.

## Structure

- Shared package (`cr_structs`): `axi4s_dp_bus_t` and `axi4s_dp_rdy_t` are reused unchanged.
- New shared constants:
  - `TLV_SOT_BIT`=0, `TLV_EOT_BIT`=1.
  - Header field positions: type [7:0], len [15:8], ext [63:16].
  - `tlv_gen_state_e` enum.
- Sub-module `cr_tlv_gen_obuf`: 2-entry skid buffer, `axi4s_dp_bus_t` wide, exposing push/full on the write side and the AXI-S master on the read side.
- Top: FSM, field latches, `remaining` counter (8-bit), `tlv_cnt`.

## Test plan

1. **Header-only TLV.** cmd type=0x05, len=1, ext=0xA, eof=1, last_strb=0x0F; tready=1.
   - One beat: tdata=0x…000A_0105, tuser=0x03, tlast=1, tstrb=0x0F.
   - `tlv_cnt`=1.
2. **Multi-word TLV.** cmd len=4, eof=0, last_strb=0x3F; payloads 0x11, 0x22, 0x33.
   - Header (SOT), beats 0x11 and 0x22 (tstrb=FF), beat 0x33 with EOT, tstrb=0x3F, tlast=0.
3. **Backpressure.** Same as test 2 with tready toggling 1,0,0,1….
   - Identical beat sequence; fields stable while tready=0.
   - `pld_ready` drops when the buffer holds 2 beats.
4. **Illegal command.** cmd len=0, then a valid len=2 command.
   - `tlv_gen_error`=1 one cycle after the first command; no output for it.
   - The second TLV is emitted normally.
5. **Back-to-back TLVs.** Three len=2 commands, eof=1 on the last only, tready=1.
   - Six beats; tlast only on beat 6.
   - 3 cycles per TLV.
   - `tlv_cnt`=3.
6. **Reset mid-TLV.** Assert `rst_n` low after the header of a len=8 TLV.
   - Outputs zero next edge-independent (async).
   - After release, a new len=1 command emits a clean SOT/EOT beat.
